// File: rtl/rob_multi_if.sv
// Dispatch, writeback and commit bundle of the multi-issue reorder buffer.
// ROB_RVFI_EN adds the per-lane/per-port RVFI trace fields.
interface rob_multi_if #(
   parameter int DEPTH      = 64,
   parameter int DISPATCH_W = 2,
   parameter int COMMIT_W   = 2,
   parameter int CDB_PORTS  = 5,
   parameter int PREG_W     = 6,
   parameter int IDX_W      = $clog2(DEPTH)
);
   logic [DISPATCH_W-1:0]              disp_valid;
   logic [DISPATCH_W-1:0][PREG_W-1:0]  disp_pd;
   logic [DISPATCH_W-1:0][4:0]         disp_rd;
   logic                               disp_ready;
   logic [DISPATCH_W-1:0][IDX_W-1:0]   disp_idx;

   logic [CDB_PORTS-1:0]               cdb_valid;
   logic [CDB_PORTS-1:0][IDX_W-1:0]    cdb_idx;
   logic [CDB_PORTS-1:0]               cdb_mispred;
   logic [CDB_PORTS-1:0][31:0]         cdb_target;

   logic [COMMIT_W-1:0]                commit_valid;
   logic [COMMIT_W-1:0][PREG_W-1:0]    commit_pd;
   logic [COMMIT_W-1:0][4:0]           commit_rd;
   logic                               flush;
   logic [31:0]                        flush_pc;
   logic [IDX_W-1:0]                   rob_head;
   logic [IDX_W:0]                     rob_count;

`ifdef ROB_RVFI_EN
   logic [DISPATCH_W-1:0][63:0]        disp_order;
   logic [DISPATCH_W-1:0][31:0]        disp_pc;
   logic [DISPATCH_W-1:0][31:0]        disp_inst;
   logic [CDB_PORTS-1:0][31:0]         cdb_rd_wdata;
   logic [COMMIT_W-1:0][63:0]          commit_order;
   logic [COMMIT_W-1:0][31:0]          commit_pc;
   logic [COMMIT_W-1:0][31:0]          commit_inst;
   logic [COMMIT_W-1:0][31:0]          commit_wdata;
`endif

   // Dispatch is accepted on an edge only when disp_ready=1; disp_valid is
   // ignored otherwise. Commit lanes carry no back-pressure.
   modport master (
      output disp_valid, disp_pd, disp_rd, cdb_valid, cdb_idx, cdb_mispred, cdb_target,
      input  disp_ready, disp_idx, commit_valid, commit_pd, commit_rd, flush, flush_pc,
             rob_head, rob_count
`ifdef ROB_RVFI_EN
      , output disp_order, disp_pc, disp_inst, cdb_rd_wdata
      , input  commit_order, commit_pc, commit_inst, commit_wdata
`endif
   );

   modport slave (
      input  disp_valid, disp_pd, disp_rd, cdb_valid, cdb_idx, cdb_mispred, cdb_target,
      output disp_ready, disp_idx, commit_valid, commit_pd, commit_rd, flush, flush_pc,
             rob_head, rob_count
`ifdef ROB_RVFI_EN
      , input  disp_order, disp_pc, disp_inst, cdb_rd_wdata
      , output commit_order, commit_pc, commit_inst, commit_wdata
`endif
   );
endinterface

// File: rtl/rob_multi.sv
// Multi-issue reorder buffer with in-order commit and precise flush at the head.
// ROB_RVFI_EN adds captured order/pc/inst/wdata per entry for the RVFI monitor.
module rob_multi #(
   parameter int DEPTH      = 64,
   parameter int DISPATCH_W = 2,
   parameter int COMMIT_W   = 2,
   parameter int CDB_PORTS  = 5,
   parameter int PREG_W     = 6,
   parameter int IDX_W      = $clog2(DEPTH)
) (
   input logic        clk,
   input logic        rst,
   rob_multi_if.slave bus
);
   localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);
   localparam logic [IDX_W:0] DISP_C  = (IDX_W+1)'(DISPATCH_W);
   localparam logic [IDX_W:0] ONE     = (IDX_W+1)'(1);

   logic [IDX_W-1:0]  head_q, tail_q;
   logic [IDX_W:0]    count_q, count_d;
   logic [DEPTH-1:0]  valid_q, done_q, mispred_q;
   logic [31:0]       target_q [DEPTH];
   logic [PREG_W-1:0] pd_q     [DEPTH];
   logic [4:0]        rd_q     [DEPTH];
`ifdef ROB_RVFI_EN
   logic [63:0]       order_q  [DEPTH];
   logic [31:0]       pc_q     [DEPTH];
   logic [31:0]       inst_q   [DEPTH];
   logic [31:0]       wdata_q  [DEPTH];
`endif

   logic                             disp_ready, flush, stop;
   logic [IDX_W:0]                   n_disp, n_commit;
   logic [DISPATCH_W-1:0][IDX_W-1:0] disp_idx;
   logic [COMMIT_W-1:0]              commit_valid;
   logic [COMMIT_W-1:0][IDX_W-1:0]   commit_idx;
   logic [31:0]                      flush_pc;

   always_comb begin
      n_disp = '0;
      for (int i = 0; i < DISPATCH_W; i++) begin
         disp_idx[i] = tail_q + IDX_W'(i);
         if (bus.disp_valid[i]) n_disp = n_disp + ONE;
      end
   end

   // A lane retires only if every older lane retired and none of them was a mispredict.
   always_comb begin
      commit_valid = '0;
      n_commit     = '0;
      flush        = 1'b0;
      flush_pc     = '0;
      stop         = 1'b0;
      for (int j = 0; j < COMMIT_W; j++) begin
         commit_idx[j] = head_q + IDX_W'(j);
         if (!stop && valid_q[commit_idx[j]] && done_q[commit_idx[j]]) begin
            commit_valid[j] = 1'b1;
            n_commit        = n_commit + ONE;
            if (mispred_q[commit_idx[j]]) begin
               flush    = 1'b1;
               flush_pc = target_q[commit_idx[j]];
               stop     = 1'b1;
            end
         end else begin
            stop = 1'b1;
         end
      end
   end

   assign disp_ready = !flush && ((DEPTH_C - count_q) >= DISP_C);
   assign count_d    = count_q + (disp_ready ? n_disp : '0) - n_commit;

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         valid_q   <= '0;
         done_q    <= '0;
         mispred_q <= '0;
      end else if (flush) begin
         head_q    <= head_q + n_commit[IDX_W-1:0];
         tail_q    <= head_q + n_commit[IDX_W-1:0];
         count_q   <= '0;
         valid_q   <= '0;
         done_q    <= '0;
         mispred_q <= '0;
      end else begin
         for (int j = 0; j < COMMIT_W; j++) begin
            if (commit_valid[j]) begin
               valid_q[commit_idx[j]]   <= 1'b0;
               done_q[commit_idx[j]]    <= 1'b0;
               mispred_q[commit_idx[j]] <= 1'b0;
            end
         end
         // Ascending port order lets the higher-numbered port win on a shared index.
         for (int p = 0; p < CDB_PORTS; p++) begin
            if (bus.cdb_valid[p] && valid_q[bus.cdb_idx[p]]) begin
               done_q[bus.cdb_idx[p]]    <= 1'b1;
               mispred_q[bus.cdb_idx[p]] <= bus.cdb_mispred[p];
               target_q[bus.cdb_idx[p]]  <= bus.cdb_target[p];
`ifdef ROB_RVFI_EN
               wdata_q[bus.cdb_idx[p]]   <= bus.cdb_rd_wdata[p];
`endif
            end
         end
         if (disp_ready) begin
            for (int i = 0; i < DISPATCH_W; i++) begin
               if (bus.disp_valid[i]) begin
                  valid_q[disp_idx[i]]   <= 1'b1;
                  done_q[disp_idx[i]]    <= 1'b0;
                  mispred_q[disp_idx[i]] <= 1'b0;
                  pd_q[disp_idx[i]]      <= bus.disp_pd[i];
                  rd_q[disp_idx[i]]      <= bus.disp_rd[i];
`ifdef ROB_RVFI_EN
                  order_q[disp_idx[i]]   <= bus.disp_order[i];
                  pc_q[disp_idx[i]]      <= bus.disp_pc[i];
                  inst_q[disp_idx[i]]    <= bus.disp_inst[i];
`endif
               end
            end
            tail_q <= tail_q + n_disp[IDX_W-1:0];
         end
         head_q  <= head_q + n_commit[IDX_W-1:0];
         count_q <= count_d;
      end
   end

   always_comb begin
      for (int j = 0; j < COMMIT_W; j++) begin
         bus.commit_pd[j] = pd_q[commit_idx[j]];
         bus.commit_rd[j] = rd_q[commit_idx[j]];
`ifdef ROB_RVFI_EN
         bus.commit_order[j] = order_q[commit_idx[j]];
         bus.commit_pc[j]    = pc_q[commit_idx[j]];
         bus.commit_inst[j]  = inst_q[commit_idx[j]];
         bus.commit_wdata[j] = wdata_q[commit_idx[j]];
`endif
      end
   end

   assign bus.disp_ready   = disp_ready;
   assign bus.disp_idx     = disp_idx;
   assign bus.commit_valid = commit_valid;
   assign bus.flush        = flush;
   assign bus.flush_pc     = flush_pc;
   assign bus.rob_head     = head_q;
   assign bus.rob_count    = count_q;
endmodule

// File: tb/tb_rob_multi.sv
// Directed bench for rob_multi (DEPTH=8): commits and flush targets are checked
// against expected queues by a negedge monitor; state checks run in the main flow.
module tb_rob_multi;
   localparam int DEPTH = 8;
   localparam int IDX_W = 3;

   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [10:0] exp_q[$];
   logic [31:0] flush_q[$];
   logic [10:0] mon_e;
   logic [31:0] mon_f;

   rob_multi_if #(.DEPTH(DEPTH), .DISPATCH_W(2), .COMMIT_W(2), .CDB_PORTS(5),
                  .PREG_W(6), .IDX_W(IDX_W)) bus ();

   rob_multi #(.DEPTH(DEPTH), .DISPATCH_W(2), .COMMIT_W(2), .CDB_PORTS(5),
               .PREG_W(6), .IDX_W(IDX_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_disp(input logic [1:0] v, input logic [5:0] pd0, input logic [4:0] rd0,
                           input logic [5:0] pd1, input logic [4:0] rd1);
      bus.disp_valid = v;
      bus.disp_pd[0] = pd0;
      bus.disp_rd[0] = rd0;
      bus.disp_pd[1] = pd1;
      bus.disp_rd[1] = rd1;
   endtask

   task automatic set_cdb(input int p, input logic [IDX_W-1:0] idx, input logic mis,
                          input logic [31:0] tgt);
      bus.cdb_valid[p]   = 1'b1;
      bus.cdb_idx[p]     = idx;
      bus.cdb_mispred[p] = mis;
      bus.cdb_target[p]  = tgt;
   endtask

   task automatic clear_in();
      bus.disp_valid  = '0;
      bus.disp_pd     = '0;
      bus.disp_rd     = '0;
      bus.cdb_valid   = '0;
      bus.cdb_idx     = '0;
      bus.cdb_mispred = '0;
      bus.cdb_target  = '0;
   endtask

   // Scoreboard monitor: every retiring lane and every flush must match the queue heads.
   always @(negedge clk) begin
      if (!rst) begin
         for (int j = 0; j < 2; j++) begin
            if (bus.commit_valid[j]) begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL commit_lane%0d: got pd=%0d rd=%0d, expected no commit",
                           j, bus.commit_pd[j], bus.commit_rd[j]);
               end else begin
                  mon_e = exp_q.pop_front();
                  if ({bus.commit_pd[j], bus.commit_rd[j]} !== mon_e) begin
                     n_fail++;
                     $display("FAIL commit_lane%0d: got pd=%0d rd=%0d, expected pd=%0d rd=%0d",
                              j, bus.commit_pd[j], bus.commit_rd[j], mon_e[10:5], mon_e[4:0]);
                  end
               end
            end
         end
         if (bus.flush) begin
            n_checks++;
            if (flush_q.size() == 0) begin
               n_fail++;
               $display("FAIL flush_pc: got flush to 0x%0h, expected no flush", bus.flush_pc);
            end else begin
               mon_f = flush_q.pop_front();
               if (bus.flush_pc !== mon_f) begin
                  n_fail++;
                  $display("FAIL flush_pc: got 0x%0h, expected 0x%0h", bus.flush_pc, mon_f);
               end
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      clear_in();
      repeat (2) step();
      rst = 1'b0;

      chk("rst_disp_ready", 32'(bus.disp_ready), 1);
      chk("rst_disp_idx0", 32'(bus.disp_idx[0]), 0);
      chk("rst_disp_idx1", 32'(bus.disp_idx[1]), 1);
      chk("rst_rob_head", 32'(bus.rob_head), 0);
      chk("rst_rob_count", 32'(bus.rob_count), 0);
      chk("rst_commit_valid", 32'(bus.commit_valid), 0);
      chk("rst_flush", 32'(bus.flush), 0);
      chk("rst_flush_pc", bus.flush_pc, 0);

      // Two-lane dispatch, then completion out of order on different ports.
      set_disp(2'b11, 6'd8, 5'd1, 6'd9, 5'd2);
      chk("t1_disp_idx0", 32'(bus.disp_idx[0]), 0);
      chk("t1_disp_idx1", 32'(bus.disp_idx[1]), 1);
      exp_q.push_back({6'd8, 5'd1});
      exp_q.push_back({6'd9, 5'd2});
      step();
      clear_in();
      chk("t1_rob_count", 32'(bus.rob_count), 2);
      chk("t1_commit_valid", 32'(bus.commit_valid), 0);
      set_cdb(3, 3'd1, 1'b0, 32'h0);
      step();
      clear_in();
      chk("t2_wait_idx0", 32'(bus.commit_valid), 0);
      set_cdb(1, 3'd0, 1'b0, 32'h0);
      step();
      clear_in();
      chk("t2_commit_valid", 32'(bus.commit_valid), 3);
      step();
      chk("t2_rob_head", 32'(bus.rob_head), 2);
      chk("t2_rob_count", 32'(bus.rob_count), 0);

      // Fill to 7 entries (idx 2..7,0); only idx 2 and 3 will ever retire.
      set_disp(2'b11, 6'd20, 5'd3, 6'd21, 5'd4);
      chk("t3_disp_idx0", 32'(bus.disp_idx[0]), 2);
      exp_q.push_back({6'd20, 5'd3});
      exp_q.push_back({6'd21, 5'd4});
      step();
      set_disp(2'b11, 6'd22, 5'd5, 6'd23, 5'd0);
      step();
      set_disp(2'b11, 6'd24, 5'd6, 6'd25, 5'd7);
      step();
      set_disp(2'b01, 6'd26, 5'd8, 6'd0, 5'd0);
      chk("t3_ready_at6", 32'(bus.disp_ready), 1);
      step();
      clear_in();
      chk("t3_rob_count7", 32'(bus.rob_count), 7);
      chk("t3_not_ready", 32'(bus.disp_ready), 0);
      // Dispatch while not ready and a CDB write to the empty slot 1: both ignored.
      set_disp(2'b11, 6'd50, 5'd9, 6'd51, 5'd9);
      set_cdb(2, 3'd1, 1'b1, 32'hbad0_0000);
      step();
      clear_in();
      chk("t6_count_kept", 32'(bus.rob_count), 7);
      chk("t6_tail_kept", 32'(bus.disp_idx[0]), 1);
      chk("t6_no_commit", 32'(bus.commit_valid), 0);
      // Same index on ports 0 and 4: port 4 (not mispredicted) wins.
      set_cdb(0, 3'd2, 1'b1, 32'hdead_beef);
      set_cdb(4, 3'd2, 1'b0, 32'h0);
      step();
      clear_in();
      chk("t3_commit_one", 32'(bus.commit_valid), 1);
      chk("t3_port_prio", 32'(bus.flush), 0);
      chk("t3_still_full", 32'(bus.disp_ready), 0);
      step();
      chk("t3_ready_after", 32'(bus.disp_ready), 1);
      chk("t3_rob_head", 32'(bus.rob_head), 3);
      chk("t3_rob_count6", 32'(bus.rob_count), 6);

      // Mispredicted branch at the head: flush squashes idx 4..7,0.
      set_cdb(0, 3'd3, 1'b1, 32'h6000_0040);
      set_cdb(1, 3'd4, 1'b0, 32'h0);
      set_cdb(2, 3'd5, 1'b0, 32'h0);
      flush_q.push_back(32'h6000_0040);
      step();
      clear_in();
      chk("t4_commit_valid", 32'(bus.commit_valid), 1);
      chk("t4_flush", 32'(bus.flush), 1);
      chk("t4_flush_pc", bus.flush_pc, 32'h6000_0040);
      chk("t4_no_disp", 32'(bus.disp_ready), 0);
      set_disp(2'b11, 6'd52, 5'd9, 6'd53, 5'd9);
      set_cdb(0, 3'd6, 1'b0, 32'h0);
      step();
      clear_in();
      chk("t4_rob_count", 32'(bus.rob_count), 0);
      chk("t4_rob_head", 32'(bus.rob_head), 4);
      chk("t4_tail", 32'(bus.disp_idx[0]), 4);
      chk("t4_no_commit", 32'(bus.commit_valid), 0);
      step();
      chk("t4_squashed", 32'(bus.commit_valid), 0);

      // Move head to 6, then dispatch four entries straddling the wrap.
      set_disp(2'b11, 6'd30, 5'd9, 6'd31, 5'd10);
      exp_q.push_back({6'd30, 5'd9});
      exp_q.push_back({6'd31, 5'd10});
      step();
      clear_in();
      set_cdb(0, 3'd4, 1'b0, 32'h0);
      set_cdb(1, 3'd5, 1'b0, 32'h0);
      step();
      clear_in();
      chk("t5_pre_commit", 32'(bus.commit_valid), 3);
      step();
      chk("t5_head6", 32'(bus.rob_head), 6);
      set_disp(2'b11, 6'd40, 5'd11, 6'd41, 5'd0);
      chk("t5_idx6", 32'(bus.disp_idx[0]), 6);
      chk("t5_idx7", 32'(bus.disp_idx[1]), 7);
      exp_q.push_back({6'd40, 5'd11});
      exp_q.push_back({6'd41, 5'd0});
      step();
      set_disp(2'b11, 6'd42, 5'd12, 6'd43, 5'd13);
      chk("t5_idx0", 32'(bus.disp_idx[0]), 0);
      chk("t5_idx1", 32'(bus.disp_idx[1]), 1);
      exp_q.push_back({6'd42, 5'd12});
      exp_q.push_back({6'd43, 5'd13});
      step();
      clear_in();
      chk("t5_count4", 32'(bus.rob_count), 4);
      set_cdb(0, 3'd1, 1'b0, 32'h0);
      set_cdb(1, 3'd0, 1'b0, 32'h0);
      set_cdb(2, 3'd7, 1'b0, 32'h0);
      set_cdb(3, 3'd6, 1'b0, 32'h0);
      step();
      clear_in();
      chk("t5_commit_67", 32'(bus.commit_valid), 3);
      chk("t5_head_67", 32'(bus.rob_head), 6);
      step();
      chk("t5_commit_01", 32'(bus.commit_valid), 3);
      chk("t5_head_01", 32'(bus.rob_head), 0);
      step();
      chk("t5_head_end", 32'(bus.rob_head), 2);
      chk("t5_count_end", 32'(bus.rob_count), 0);
      chk("t5_idle", 32'(bus.commit_valid), 0);

      repeat (2) step();
      chk("exp_q_drained", 32'(exp_q.size()), 0);
      chk("flush_q_drained", 32'(flush_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
